vec_mul_ctrl: RTL

- Sequencer for the 64x64 vector-multiplier array of weight-stationary PEs.
- Weight load: steps through weight memory one row per cycle and pulses each row's `weight_reload` in turn.
- Run: streams input vectors into the array with a valid/ready handshake and tracks the array's fixed pipeline latency to flag valid outputs.
- Sits between the host command interface, the weight memory and the PE array; owns no arithmetic.

---
 rtl/vec_mul_pkg.sv | 20 ++
 rtl/valid_delay.sv | 27 ++
 rtl/vec_mul_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vec_mul_pkg.sv
// Shared types and default parameters for the vector-multiplier array sequencer.
package vec_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_FLUSH,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int N_ROWS_DEF   = 64;
    localparam int ADDR_BW_DEF  = 6;
    localparam int PIPE_LAT_DEF = 2;
    localparam int LEN_BW_DEF   = 16;

    // Weight-memory read latency in cycles; sets the depth of the reload strobe pipeline.
    localparam int MEM_RD_LAT   = 1;

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register with synchronous clear; delays a single valid bit by DEPTH cycles.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    // NOTE: sequential state is always written with <= so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vec_mul_ctrl.sv
// Sequencer for the weight-stationary PE array: walks weight memory for loads and
// streams input vectors for runs, tracking the array latency to flag valid outputs.
module vec_mul_ctrl
    import vec_mul_pkg::*;
#(
    parameter int N_ROWS   = N_ROWS_DEF,
    parameter int ADDR_BW  = ADDR_BW_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int LEN_BW   = LEN_BW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_load,
    input  logic               cmd_run,
    input  logic [LEN_BW-1:0]  run_len,
    output logic               busy,
    output logic               w_mem_en,
    output logic [ADDR_BW-1:0] w_mem_addr,
    output logic [N_ROWS-1:0]  weight_reload,
    input  logic               x_valid,
    output logic               x_ready,
    output logic               pe_data_en,
    output logic               y_valid,
    output logic               done
);

    localparam int                  DRAIN_BW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_BW-1:0] DRAIN_LAST = DRAIN_BW'(PIPE_LAT - 1);
    localparam logic [ADDR_BW-1:0]  LAST_ROW   = ADDR_BW'(N_ROWS - 1);

    state_t              state_q, state_d;
    logic [ADDR_BW-1:0]  addr_q;
    logic [LEN_BW-1:0]   run_cnt_q;
    logic [LEN_BW-1:0]   len_q;
    logic [DRAIN_BW-1:0] drain_q;
    logic                done_q, done_d;

    logic                rl_en_q   [MEM_RD_LAT];
    logic [ADDR_BW-1:0]  rl_addr_q [MEM_RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        busy     = (state_q != ST_IDLE);
        w_mem_en = (state_q == ST_LOAD);
        x_ready  = (state_q == ST_RUN) && (run_cnt_q < len_q);
        unique case (state_q)
            ST_IDLE: begin
                // The done cycle itself still blocks commands, so a new one lands the cycle after.
                if (!done_q) begin
                    if (cmd_load)     state_d = ST_LOAD;
                    else if (cmd_run) state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (addr_q == LAST_ROW) state_d = ST_LOAD_FLUSH;
            end
            ST_LOAD_FLUSH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_RUN: begin
                if (len_q == '0 || (pe_data_en && run_cnt_q == len_q - LEN_BW'(1)))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pe_data_en = x_valid & x_ready;
    assign w_mem_addr = addr_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            run_cnt_q <= '0;
            len_q     <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            addr_q  <= (state_q == ST_LOAD)  ? addr_q + ADDR_BW'(1)   : '0;
            drain_q <= (state_q == ST_DRAIN) ? drain_q + DRAIN_BW'(1) : '0;
            if (state_q == ST_IDLE) begin
                run_cnt_q <= '0;
                if (state_d == ST_RUN) len_q <= run_len;
            end else if (pe_data_en) begin
                run_cnt_q <= run_cnt_q + LEN_BW'(1);
            end
        end
    end

    // Reload strobe follows the memory read by MEM_RD_LAT cycles so each row sees its own data.
    // NOTE: this is a small pipeline, not a memory array, so it is reset to keep strobes off in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                rl_en_q[i]   <= 1'b0;
                rl_addr_q[i] <= '0;
            end
        end else begin
            rl_en_q[0]   <= w_mem_en;
            rl_addr_q[0] <= addr_q;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                rl_en_q[i]   <= rl_en_q[i-1];
                rl_addr_q[i] <= rl_addr_q[i-1];
            end
        end
    end

    always_comb begin
        weight_reload = '0;
        if (rl_en_q[MEM_RD_LAT-1]) weight_reload[rl_addr_q[MEM_RD_LAT-1]] = 1'b1;
    end

    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_y_delay (
        .clk  (clk),
        .clr  (rst),
        .din  (pe_data_en),
        .dout (y_valid)
    );

endmodule
